// File: rtl/parking_slot_allocator.sv
// parking_slot_allocator: lowest-free slot allocator with timed entry gate; define PARK_EXIT_CHECK_EN for exit validity checking
module parking_slot_allocator #(
  parameter int SLOTS       = 8,
  parameter int GATE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       entry_req,
  output logic                       entry_ack,
  output logic [$clog2(SLOTS)-1:0]   entry_slot,
  input  logic                       exit_valid,
  input  logic [SLOTS-1:0]           exit_location,
  output logic [SLOTS-1:0]           occupancy,
  output logic [$clog2(SLOTS+1)-1:0] free_count,
  output logic                       full,
`ifdef PARK_EXIT_CHECK_EN
  output logic                       exit_err,
`endif
  output logic                       gate_open
);
  localparam int SW = $clog2(SLOTS);
  localparam int FW = $clog2(SLOTS + 1);
  localparam int CW = GATE_CYCLES > 1 ? $clog2(GATE_CYCLES) : 1;
  typedef enum logic {IDLE, GATE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] alloc_idx;
  logic [FW-1:0] used;
  logic [SLOTS-1:0] alloc_onehot, exit_mask;
  logic alloc;
  always_comb begin
    alloc_idx = '0;
    used = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      alloc_idx = occupancy[i] ? alloc_idx : SW'(i);
      used = used + FW'(occupancy[i]);
    end
  end
  assign free_count = FW'(SLOTS) - used;
  assign full = &occupancy;
  assign alloc = state == IDLE && entry_req && !full;
  assign alloc_onehot = alloc ? SLOTS'(1) << alloc_idx : '0;
`ifdef PARK_EXIT_CHECK_EN
  logic bad;
  assign bad = exit_valid && (exit_location == '0 || (exit_location & (exit_location - 1'b1)) != '0
                              || (exit_location & ~occupancy) != '0);
  assign exit_mask = exit_valid && !bad ? exit_location : '0;
`else
  assign exit_mask = exit_valid ? exit_location : '0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      occupancy  <= '0;
      entry_ack  <= 1'b0;
      entry_slot <= '0;
      gate_open  <= 1'b0;
`ifdef PARK_EXIT_CHECK_EN
      exit_err   <= 1'b0;
`endif
    end else begin
      entry_ack <= 1'b0;
`ifdef PARK_EXIT_CHECK_EN
      exit_err  <= bad;
`endif
      occupancy <= (occupancy & ~exit_mask) | alloc_onehot;
      if (alloc) begin
        entry_slot <= alloc_idx;
        entry_ack  <= 1'b1;
        gate_open  <= 1'b1;
        cnt        <= CW'(GATE_CYCLES - 1);
        state      <= GATE;
      end else if (state == GATE) begin
        cnt       <= cnt == '0 ? cnt : cnt - 1'b1;
        gate_open <= cnt != '0;
        state     <= cnt == '0 ? IDLE : GATE;
      end
    end
  end
endmodule

// File: tb/tb_parking_slot_allocator.sv
// tb_parking_slot_allocator: directed self-checking bench for parking_slot_allocator
module tb_parking_slot_allocator;
  logic clk = 1'b0, rst_n = 1'b0, entry_req = 1'b0, exit_valid = 1'b0;
  logic [7:0] exit_location = '0;
  logic entry_ack, full, gate_open;
  logic [2:0] entry_slot;
  logic [7:0] occupancy;
  logic [3:0] free_count;
`ifdef PARK_EXIT_CHECK_EN
  logic exit_err;
`endif
  int checks = 0, errors = 0;
  bit acked;
  always #5 clk = ~clk;
  parking_slot_allocator dut (
    .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .entry_ack(entry_ack),
    .entry_slot(entry_slot), .exit_valid(exit_valid), .exit_location(exit_location),
    .occupancy(occupancy), .free_count(free_count), .full(full),
`ifdef PARK_EXIT_CHECK_EN
    .exit_err(exit_err),
`endif
    .gate_open(gate_open)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic car(input logic [2:0] slot);
    entry_req = 1'b1;
    tick();
    chk("car_ack", 32'(entry_ack), 1);
    chk("car_slot", 32'(entry_slot), 32'(slot));
    entry_req = 1'b0;
    repeat (4) tick();
  endtask
  initial begin
    #12;
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_free", 32'(free_count), 8);
    chk("rst_full", 32'(full), 0);
    chk("rst_ack", 32'(entry_ack), 0);
    chk("rst_slot", 32'(entry_slot), 0);
    chk("rst_gate", 32'(gate_open), 0);
    rst_n = 1'b1;
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    chk("t1_ack", 32'(entry_ack), 1);
    chk("t1_slot", 32'(entry_slot), 0);
    chk("t1_occ", 32'(occupancy), 32'h01);
    chk("t1_free", 32'(free_count), 7);
    chk("t1_gate0", 32'(gate_open), 1);
    tick();
    chk("t1_ack_pulse", 32'(entry_ack), 0);
    chk("t1_gate1", 32'(gate_open), 1);
    tick();
    chk("t1_gate2", 32'(gate_open), 1);
    tick();
    chk("t1_gate3", 32'(gate_open), 1);
    tick();
    chk("t1_gate_close", 32'(gate_open), 0);
    tick();
    for (int i = 1; i < 8; i++) car(3'(i));
    chk("t2_occ", 32'(occupancy), 32'hFF);
    chk("t2_full", 32'(full), 1);
    chk("t2_free", 32'(free_count), 0);
    entry_req = 1'b1;
    acked = 1'b0;
    repeat (20) begin
      tick();
      acked |= entry_ack;
    end
    chk("t2_no_ack_full", 32'(acked), 0);
    exit_valid = 1'b1;
    exit_location = 8'h08;
    tick();
    exit_valid = 1'b0;
    chk("t3_occ_exit", 32'(occupancy), 32'hF7);
    chk("t3_no_same_edge_ack", 32'(entry_ack), 0);
    chk("t3_not_full", 32'(full), 0);
    tick();
    entry_req = 1'b0;
    chk("t3_ack", 32'(entry_ack), 1);
    chk("t3_slot", 32'(entry_slot), 3);
    chk("t3_full", 32'(full), 1);
    repeat (4) tick();
    for (int i = 2; i < 8; i++) begin
      exit_valid = 1'b1;
      exit_location = 8'(1 << i);
      tick();
    end
    exit_valid = 1'b0;
    chk("t4_pre_occ", 32'(occupancy), 32'h03);
    chk("t4_pre_free", 32'(free_count), 6);
    entry_req = 1'b1;
    exit_valid = 1'b1;
    exit_location = 8'h01;
    tick();
    entry_req = 1'b0;
    exit_valid = 1'b0;
    chk("t4_ack", 32'(entry_ack), 1);
    chk("t4_slot", 32'(entry_slot), 2);
    chk("t4_occ", 32'(occupancy), 32'h06);
    repeat (4) tick();
    car(3'd0);
    car(3'd3);
    chk("t5_pre_occ", 32'(occupancy), 32'h0F);
    exit_valid = 1'b1;
    exit_location = 8'h03;
    tick();
    exit_valid = 1'b0;
`ifdef PARK_EXIT_CHECK_EN
    chk("t5_err_multi", 32'(exit_err), 1);
    chk("t5_occ_keep_multi", 32'(occupancy), 32'h0F);
    tick();
    chk("t5_err_pulse", 32'(exit_err), 0);
    exit_valid = 1'b1;
    exit_location = 8'h10;
    tick();
    exit_valid = 1'b0;
    chk("t5_err_unocc", 32'(exit_err), 1);
    chk("t5_occ_keep_unocc", 32'(occupancy), 32'h0F);
    tick();
    chk("t5_err_clear", 32'(exit_err), 0);
`else
    chk("t5_occ_multi", 32'(occupancy), 32'h0C);
    exit_valid = 1'b1;
    exit_location = 8'h00;
    tick();
    chk("t5_zero_noop", 32'(occupancy), 32'h0C);
    exit_location = 8'h10;
    tick();
    exit_valid = 1'b0;
    chk("t5_unocc_noop", 32'(occupancy), 32'h0C);
    chk("t5_free", 32'(free_count), 6);
`endif
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    chk("t6_ack", 32'(entry_ack), 1);
    tick();
    chk("t6_gate_mid", 32'(gate_open), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_gate", 32'(gate_open), 0);
    chk("t6_occ", 32'(occupancy), 0);
    chk("t6_free", 32'(free_count), 8);
    chk("t6_ack_rst", 32'(entry_ack), 0);
    #1 rst_n = 1'b1;
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    chk("t6_realloc_ack", 32'(entry_ack), 1);
    chk("t6_realloc_slot", 32'(entry_slot), 0);
    chk("t6_realloc_occ", 32'(occupancy), 32'h01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
